alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 38 +++
 rtl/alu.sv | 38 +++
 tb/tb_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
// Imported by the datapath, the registered top and the testbench.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROTL = 4'd6,
        OP_ROTR = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: unsigned operands, results truncated
// to WIDTH bits, compares zero-extended.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       sel_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (alu_op_e'(sel_i))
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_MUL:  result_o = a_i * b_i;
            // A zero divisor yields 0 instead of the simulator's X.
            OP_DIV:  result_o = (b_i == '0) ? '0 : (a_i / b_i);
            OP_SHL:  result_o = {a_i[WIDTH-2:0], 1'b0};
            OP_SHR:  result_o = {1'b0, a_i[WIDTH-1:1]};
            OP_ROTL: result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            OP_ROTR: result_o = {a_i[0], a_i[WIDTH-1:1]};
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_NAND: result_o = ~(a_i & b_i);
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_GT:   result_o = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
            OP_EQ:   result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: the combinational core plus a single output register
// that clears asynchronously while reset is low.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out
);

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (A),
        .b_i      (B),
        .sel_i    (ALU_Sel),
        .result_o (alu_out_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALU_Out = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the registered ALU: directed reset/opcode cases, a mid-cycle
// reset pulse, then random operations against an integer-arithmetic model.
module tb_alu;
    import alu_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;

    int n_cmp = 0;
    int n_bad = 0;

    alu #(
        .WIDTH (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference built from plain integer arithmetic on values 0..255.
    function automatic logic [7:0] model(input int a, input int b, input int s);
        int v;
        case (s)
            0:  v = (a + b) % 256;
            1:  v = (a - b + 256) % 256;
            2:  v = (a * b) % 256;
            3:  v = (b == 0) ? 0 : a / b;
            4:  v = (a * 2) % 256;
            5:  v = a / 2;
            6:  v = (a * 2) % 256 + a / 128;
            7:  v = a / 2 + (a % 2) * 128;
            8:  v = a & b;
            9:  v = a | b;
            10: v = a ^ b;
            11: v = 255 - (a | b);
            12: v = 255 - (a & b);
            13: v = 255 - (a ^ b);
            14: v = (a > b) ? 1 : 0;
            default: v = (a == b) ? 1 : 0;
        endcase
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic dstep(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [7:0] exp);
        @(negedge clock);
        A = a;
        B = b;
        ALU_Sel = s;
        @(posedge clock);
        #1;
        check(tag, ALU_Out, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rs;

        reset = 1'b0;
        A = 8'hFF;
        B = 8'h01;
        ALU_Sel = OP_ADD;
        #1;
        check("rst_async", ALU_Out, 8'h00);
        repeat (3) begin
            @(posedge clock);
            #1;
            check("rst_hold", ALU_Out, 8'h00);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release_wrap", ALU_Out, 8'h00);
        dstep("sub_after_rst", 8'hFF, 8'h01, OP_SUB, 8'hFE);

        dstep("add_wrap", 8'd200, 8'd100, OP_ADD, 8'd44);
        dstep("sub",      8'd200, 8'd100, OP_SUB, 8'd100);
        dstep("mul_wrap", 8'd200, 8'd100, OP_MUL, 8'h20);
        dstep("div",      8'd200, 8'd100, OP_DIV, 8'd2);
        dstep("div_zero", 8'd7,   8'd0,   OP_DIV, 8'd0);
        dstep("sub_neg",  8'd5,   8'd7,   OP_SUB, 8'hFE);
        dstep("shl",  8'b1000_0001, 8'h00, OP_SHL,  8'b0000_0010);
        dstep("shr",  8'b1000_0001, 8'h00, OP_SHR,  8'b0100_0000);
        dstep("rotl", 8'b1000_0001, 8'h00, OP_ROTL, 8'b0000_0011);
        dstep("rotr", 8'b1000_0001, 8'h00, OP_ROTR, 8'b1100_0000);
        dstep("and",  8'hF0, 8'hCC, OP_AND,  8'hC0);
        dstep("or",   8'hF0, 8'hCC, OP_OR,   8'hFC);
        dstep("xor",  8'hF0, 8'hCC, OP_XOR,  8'h3C);
        dstep("nor",  8'hF0, 8'hCC, OP_NOR,  8'h03);
        dstep("nand", 8'hF0, 8'hCC, OP_NAND, 8'h3F);
        dstep("xnor", 8'hF0, 8'hCC, OP_XNOR, 8'hC3);
        dstep("gt_eq_ops", 8'h55, 8'h55, OP_GT, 8'h00);
        dstep("eq",        8'h55, 8'h55, OP_EQ, 8'h01);
        dstep("gt_true",   8'h56, 8'h55, OP_GT, 8'h01);

        // Mid-cycle input change, then a reset pulse between edges.
        dstep("pre_pulse", 8'd200, 8'd100, OP_ADD, 8'd44);
        #2;
        A = 8'd3;
        B = 8'd9;
        ALU_Sel = OP_MUL;
        #1;
        check("hold_between_edges", ALU_Out, 8'd44);
        reset = 1'b0;
        #1;
        check("rst_mid_async", ALU_Out, 8'h00);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_released_pre_edge", ALU_Out, 8'h00);
        @(posedge clock);
        #1;
        check("post_release_result", ALU_Out, 8'd27);
        dstep("latency_after_pulse", 8'd12, 8'd5, OP_XOR, 8'd9);

        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rb = ra;
            rs = 4'($urandom_range(0, 15));
            dstep("random", ra, rb, rs, model(int'(ra), int'(rb), int'(rs)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
